// File: rtl/rtu_rsp_pkg.sv
// Shared types for the RTU port responder: FSM state, rule entry and latched request.
// Field widths are fixed at the widest supported configuration; instances slice what they need.
package rtu_rsp_pkg;

    localparam int RSP_MAC_BITS      = 48;
    localparam int RSP_VID_BITS      = 12;
    localparam int RSP_PRIO_BITS     = 3;
    localparam int RSP_MASK_BITS_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESPOND
    } rsp_state_t;

    typedef struct packed {
        logic                         valid;
        logic [RSP_MAC_BITS-1:0]      mac;
        logic [RSP_MASK_BITS_MAX-1:0] mask;
    } rsp_rule_t;

    typedef struct packed {
        logic [RSP_MAC_BITS-1:0]  smac;
        logic [RSP_MAC_BITS-1:0]  dmac;
        logic [RSP_VID_BITS-1:0]  vid;
        logic                     has_vid;
        logic [RSP_PRIO_BITS-1:0] prio;
        logic                     has_prio;
    } rsp_req_t;

    function automatic logic rule_hit(input rsp_rule_t rule, input logic [RSP_MAC_BITS-1:0] dmac);
        return rule.valid && (rule.mac == dmac);
    endfunction

endpackage

// File: rtl/rtu_rsp_rule_table.sv
// Static rule storage: one write port, one combinational indexed read port.
// Reset invalidates every entry so a fresh lookup always floods.
module rtu_rsp_rule_table
    import rtu_rsp_pkg::*;
#(
    parameter int g_num_rules = 8,
    parameter int g_idx_width = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [g_idx_width-1:0] wr_idx_i,
    input  rsp_rule_t              wr_rule_i,
    input  logic [g_idx_width-1:0] rd_idx_i,
    output rsp_rule_t              rd_rule_o
);

    rsp_rule_t rules [g_num_rules];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < g_num_rules; i++) begin
                rules[i] <= '0;
            end
        end else if (we_i && (int'(wr_idx_i) < g_num_rules)) begin
            rules[wr_idx_i] <= wr_rule_i;
        end
    end

    assign rd_rule_o = rules[rd_idx_i];

endmodule

// File: rtl/rtu_port_responder.sv
// Per-port RTU responder: latches a request, scans the rule table one entry per cycle,
// then holds a forwarding decision until acknowledged. Define RTU_RSP_STATS_EN for rq_ovf_cnt_o.
module rtu_port_responder
    import rtu_rsp_pkg::*;
#(
    parameter int g_num_rules      = 8,
    parameter int g_mac_addr_width = 48,
    parameter int g_vid_width      = 12,
    parameter int g_prio_width     = 3,
    parameter int g_port_mask_bits = 9,
    parameter int g_port_id        = 0,
    localparam int IDX_W           = (g_num_rules > 1) ? $clog2(g_num_rules) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rq_strobe_p_i,
    input  logic [g_mac_addr_width-1:0] rq_smac_i,
    input  logic [g_mac_addr_width-1:0] rq_dmac_i,
    input  logic [g_vid_width-1:0]      rq_vid_i,
    input  logic                        rq_has_vid_i,
    input  logic [g_prio_width-1:0]     rq_prio_i,
    input  logic                        rq_has_prio_i,
    output logic                        rq_full_o,
`ifdef RTU_RSP_STATS_EN
    output logic [7:0]                  rq_ovf_cnt_o,
`endif
    output logic                        rsp_valid_o,
    output logic [g_port_mask_bits-1:0] rsp_port_mask_o,
    output logic                        rsp_drop_o,
    output logic [g_prio_width-1:0]     rsp_prio_o,
    input  logic                        rsp_ack_i,
    input  logic                        cfg_we_i,
    input  logic [IDX_W-1:0]            cfg_idx_i,
    input  logic [g_mac_addr_width-1:0] cfg_mac_i,
    input  logic [g_port_mask_bits-1:0] cfg_mask_i,
    input  logic                        cfg_valid_i,
    input  logic                        cfg_enable_i,
    input  logic [g_port_mask_bits-1:0] cfg_def_mask_i,
    input  logic [g_prio_width-1:0]     cfg_def_prio_i
);

    localparam int CNT_W = $clog2(g_num_rules + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(g_num_rules);
    localparam logic [g_port_mask_bits-1:0] HAIRPIN = g_port_mask_bits'(1) << g_port_id;

    rsp_state_t                  state_reg;
    rsp_req_t                    req_reg;
    logic [CNT_W-1:0]            cnt_reg;
    logic                        found_reg;
    logic [g_port_mask_bits-1:0] hit_mask_reg;

    rsp_rule_t                   wr_rule;
    rsp_rule_t                   rd_rule;
    logic [g_port_mask_bits-1:0] sel_mask;
    logic [g_port_mask_bits-1:0] final_mask;
    logic                        final_drop;
    logic [g_prio_width-1:0]     final_prio;

    assign wr_rule.valid = cfg_valid_i;
    assign wr_rule.mac   = RSP_MAC_BITS'(cfg_mac_i);
    assign wr_rule.mask  = RSP_MASK_BITS_MAX'(cfg_mask_i);

    rtu_rsp_rule_table #(
        .g_num_rules (g_num_rules),
        .g_idx_width (IDX_W)
    ) u_rule_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (cfg_we_i),
        .wr_idx_i  (cfg_idx_i),
        .wr_rule_i (wr_rule),
        .rd_idx_i  (cnt_reg[IDX_W-1:0]),
        .rd_rule_o (rd_rule)
    );

    // Default mask and enable are sampled only in the final LOOKUP cycle.
    assign sel_mask   = found_reg ? hit_mask_reg : cfg_def_mask_i;
    assign final_mask = sel_mask & ~HAIRPIN;
    assign final_drop = !cfg_enable_i || (final_mask == '0);
    assign final_prio = req_reg.has_prio ? g_prio_width'(req_reg.prio) : cfg_def_prio_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= ST_IDLE;
            req_reg         <= '0;
            cnt_reg         <= '0;
            found_reg       <= 1'b0;
            hit_mask_reg    <= '0;
            rq_full_o       <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_port_mask_o <= '0;
            rsp_drop_o      <= 1'b0;
            rsp_prio_o      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rq_strobe_p_i) begin
                        req_reg.smac     <= RSP_MAC_BITS'(rq_smac_i);
                        req_reg.dmac     <= RSP_MAC_BITS'(rq_dmac_i);
                        req_reg.vid      <= RSP_VID_BITS'(rq_vid_i);
                        req_reg.has_vid  <= rq_has_vid_i;
                        req_reg.prio     <= RSP_PRIO_BITS'(rq_prio_i);
                        req_reg.has_prio <= rq_has_prio_i;
                        cnt_reg          <= '0;
                        found_reg        <= 1'b0;
                        hit_mask_reg     <= '0;
                        rq_full_o        <= 1'b1;
                        state_reg        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cnt_reg == LAST_CNT) begin
                        rsp_valid_o     <= 1'b1;
                        rsp_port_mask_o <= final_drop ? '0 : final_mask;
                        rsp_drop_o      <= final_drop;
                        rsp_prio_o      <= final_prio;
                        state_reg       <= ST_RESPOND;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // First hit wins; later matching rules are ignored.
                        if (!found_reg && rule_hit(rd_rule, req_reg.dmac)) begin
                            found_reg    <= 1'b1;
                            hit_mask_reg <= rd_rule.mask[g_port_mask_bits-1:0];
                        end
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ack_i) begin
                        rsp_valid_o <= 1'b0;
                        rq_full_o   <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef RTU_RSP_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rq_ovf_cnt_o <= '0;
        end else if (rq_strobe_p_i && rq_full_o && (rq_ovf_cnt_o != 8'hFF)) begin
            rq_ovf_cnt_o <= rq_ovf_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rtu_port_responder.sv
// Directed bench for rtu_port_responder; expected responses queue up at strobe time
// and are popped when rsp_valid_o rises. Covers RTU_RSP_STATS_EN when defined.
`timescale 1ns/1ps
module tb_rtu_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq_strobe_p;
    logic [47:0] rq_smac;
    logic [47:0] rq_dmac;
    logic [11:0] rq_vid;
    logic        rq_has_vid;
    logic [2:0]  rq_prio;
    logic        rq_has_prio;
    logic        rq_full;
    logic        rsp_valid;
    logic [8:0]  rsp_port_mask;
    logic        rsp_drop;
    logic [2:0]  rsp_prio;
    logic        rsp_ack;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [47:0] cfg_mac;
    logic [8:0]  cfg_mask;
    logic        cfg_valid;
    logic        cfg_enable;
    logic [8:0]  cfg_def_mask;
    logic [2:0]  cfg_def_prio;
`ifdef RTU_RSP_STATS_EN
    logic [7:0]  rq_ovf_cnt;
`endif

    rtu_port_responder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rq_strobe_p_i   (rq_strobe_p),
        .rq_smac_i       (rq_smac),
        .rq_dmac_i       (rq_dmac),
        .rq_vid_i        (rq_vid),
        .rq_has_vid_i    (rq_has_vid),
        .rq_prio_i       (rq_prio),
        .rq_has_prio_i   (rq_has_prio),
        .rq_full_o       (rq_full),
`ifdef RTU_RSP_STATS_EN
        .rq_ovf_cnt_o    (rq_ovf_cnt),
`endif
        .rsp_valid_o     (rsp_valid),
        .rsp_port_mask_o (rsp_port_mask),
        .rsp_drop_o      (rsp_drop),
        .rsp_prio_o      (rsp_prio),
        .rsp_ack_i       (rsp_ack),
        .cfg_we_i        (cfg_we),
        .cfg_idx_i       (cfg_idx),
        .cfg_mac_i       (cfg_mac),
        .cfg_mask_i      (cfg_mask),
        .cfg_valid_i     (cfg_valid),
        .cfg_enable_i    (cfg_enable),
        .cfg_def_mask_i  (cfg_def_mask),
        .cfg_def_prio_i  (cfg_def_prio)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] mask;
        logic       drop;
        logic [2:0] prio;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   strobe_cyc = 0;

    localparam logic [47:0] MAC_A = 48'h0650_cafe_babe;
    localparam logic [47:0] MAC_U = 48'h0050_cafe_babe;
    localparam logic [47:0] MAC_B = 48'h1111_2222_3333;
    localparam logic [47:0] MAC_C = 48'h4444_5555_6666;
    localparam logic [47:0] MAC_X = 48'h7777_8888_9999;

    `define CHK(tag, obs, exp) \
        begin \
            checks++; \
            assert ((obs) === (exp)) else begin \
                errors++; \
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); \
            end \
        end

    task automatic cfg_rule(input int idx, input logic [47:0] mac, input logic [8:0] mask, input logic v);
        cfg_we    = 1'b1;
        cfg_idx   = 3'(idx);
        cfg_mac   = mac;
        cfg_mask  = mask;
        cfg_valid = v;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    task automatic start_req(input logic [47:0] dmac, input logic hp, input logic [2:0] p,
                             input logic [8:0] emask, input logic edrop, input logic [2:0] eprio);
        exp_t e;
        rq_strobe_p = 1'b1;
        rq_dmac     = dmac;
        rq_smac     = 48'h00aa_bbcc_ddee;
        rq_vid      = 12'h123;
        rq_has_vid  = 1'b1;
        rq_has_prio = hp;
        rq_prio     = p;
        @(posedge clk); #1;
        rq_strobe_p = 1'b0;
        strobe_cyc  = cyc;
        e.mask = emask; e.drop = edrop; e.prio = eprio;
        sb.push_back(e);
        `CHK("full_after_strobe", rq_full, 1'b1)
        $display("req   dmac=%012h has_prio=%0b prio=%0d -> expect mask=%03h drop=%0b prio=%0d",
                 dmac, hp, p, emask, edrop, eprio);
    endtask

    task automatic wait_rsp(input string tag);
        exp_t e;
        while (!rsp_valid && (cyc - strobe_cyc) < 30) begin
            @(posedge clk); #1;
        end
        `CHK({tag, "_latency"}, cyc - strobe_cyc, 9)
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            `CHK({tag, "_mask"}, rsp_port_mask, e.mask)
            `CHK({tag, "_drop"}, rsp_drop, e.drop)
            `CHK({tag, "_prio"}, rsp_prio, e.prio)
        end
        $display("rsp   %s valid=%0b mask=%03h drop=%0b prio=%0d", tag, rsp_valid, rsp_port_mask, rsp_drop, rsp_prio);
    endtask

    task automatic ack_rsp(input string tag);
        rsp_ack = 1'b1;
        @(posedge clk); #1;
        rsp_ack = 1'b0;
        `CHK({tag, "_valid_after_ack"}, rsp_valid, 1'b0)
        `CHK({tag, "_full_after_ack"}, rq_full, 1'b0)
    endtask

    initial begin : stim
        logic [8:0] hold_mask;
        logic       hold_drop;
        logic [2:0] hold_prio;
        int         unstable;
        int         stray;

        rst = 1'b1; rq_strobe_p = 1'b0; rq_smac = '0; rq_dmac = '0; rq_vid = '0;
        rq_has_vid = 1'b0; rq_prio = '0; rq_has_prio = 1'b0; rsp_ack = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_mac = '0; cfg_mask = '0; cfg_valid = 1'b0;
        cfg_enable = 1'b1; cfg_def_mask = 9'h1FF; cfg_def_prio = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        `CHK("reset_valid", rsp_valid, 1'b0)
        `CHK("reset_mask", rsp_port_mask, 9'h000)
        `CHK("reset_drop", rsp_drop, 1'b0)
        `CHK("reset_prio", rsp_prio, 3'd0)
        `CHK("reset_full", rq_full, 1'b0)
        rst = 1'b0;
        @(posedge clk); #1;

        cfg_rule(0, MAC_A, 9'h002, 1'b1);
        start_req(MAC_A, 1'b0, 3'd6, 9'h002, 1'b0, 3'd0);
        wait_rsp("rule0_hit");
        ack_rsp("rule0_hit");

        start_req(MAC_U, 1'b0, 3'd0, 9'h1FE, 1'b0, 3'd0);
        wait_rsp("flood");
        ack_rsp("flood");

        cfg_rule(2, MAC_B, 9'h004, 1'b1);
        cfg_rule(5, MAC_B, 9'h020, 1'b1);
        start_req(MAC_B, 1'b0, 3'd0, 9'h004, 1'b0, 3'd0);
        wait_rsp("lowest_idx");
        ack_rsp("lowest_idx");

        cfg_rule(1, MAC_C, 9'h001, 1'b1);
        start_req(MAC_C, 1'b0, 3'd0, 9'h000, 1'b1, 3'd0);
        wait_rsp("hairpin_drop");
        ack_rsp("hairpin_drop");

        start_req(MAC_A, 1'b1, 3'd5, 9'h002, 1'b0, 3'd5);
        wait_rsp("req_prio");
        ack_rsp("req_prio");

        cfg_def_prio = 3'd3;
        start_req(MAC_U, 1'b0, 3'd7, 9'h1FE, 1'b0, 3'd3);
        wait_rsp("def_prio");
        ack_rsp("def_prio");
        cfg_def_prio = 3'd0;

        cfg_enable = 1'b0;
        start_req(MAC_A, 1'b0, 3'd0, 9'h000, 1'b1, 3'd0);
        wait_rsp("disabled");
        ack_rsp("disabled");
        cfg_enable = 1'b1;

        // Rule 7 written before it is scanned counts; rule 1 written after its slot does not.
        start_req(MAC_X, 1'b0, 3'd0, 9'h080, 1'b0, 3'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_rule(7, MAC_X, 9'h080, 1'b1);
        cfg_rule(1, MAC_X, 9'h002, 1'b1);
        wait_rsp("mid_scan_write");
        ack_rsp("mid_scan_write");
        start_req(MAC_X, 1'b0, 3'd0, 9'h002, 1'b0, 3'd0);
        wait_rsp("after_scan_write");
        ack_rsp("after_scan_write");

        start_req(MAC_A, 1'b0, 3'd0, 9'h002, 1'b0, 3'd0);
        wait_rsp("hold");
        hold_mask = rsp_port_mask; hold_drop = rsp_drop; hold_prio = rsp_prio;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            rq_strobe_p = (i == 3);
            rq_dmac     = MAC_U;
            @(posedge clk); #1;
            rq_strobe_p = 1'b0;
            if (!rsp_valid || !rq_full || rsp_port_mask !== hold_mask ||
                rsp_drop !== hold_drop || rsp_prio !== hold_prio) unstable++;
        end
        `CHK("hold_stable_cycles_bad", unstable, 0)
`ifdef RTU_RSP_STATS_EN
        `CHK("ovf_cnt_one", rq_ovf_cnt, 8'd1)
`endif
        rq_strobe_p = 1'b1;
        ack_rsp("hold");
        rq_strobe_p = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || rq_full) stray++;
        end
        `CHK("ack_cycle_strobe_ignored", stray, 0)
`ifdef RTU_RSP_STATS_EN
        `CHK("ovf_cnt_two", rq_ovf_cnt, 8'd2)
`endif

        // Abort mid-LOOKUP: outputs clear at once and the request never answers.
        rq_strobe_p = 1'b1; rq_dmac = MAC_A; rq_has_prio = 1'b1; rq_prio = 3'd7;
        @(posedge clk); #1;
        rq_strobe_p = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        `CHK("abort_valid", rsp_valid, 1'b0)
        `CHK("abort_mask", rsp_port_mask, 9'h000)
        `CHK("abort_drop", rsp_drop, 1'b0)
        `CHK("abort_prio", rsp_prio, 3'd0)
        `CHK("abort_full", rq_full, 1'b0)
`ifdef RTU_RSP_STATS_EN
        `CHK("abort_ovf_cnt", rq_ovf_cnt, 8'd0)
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) stray++;
        end
        `CHK("abort_no_response", stray, 0)
        $display("abort reset applied mid-lookup, stray responses=%0d", stray);

        start_req(MAC_A, 1'b0, 3'd0, 9'h1FE, 1'b0, 3'd0);
        wait_rsp("rules_cleared");
        ack_rsp("rules_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtu_port_responder.md
RTU_PORT_RESPONDER -- requirements
Module: rtu_port_responder

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: g_num_rules 8 static rules scanned; g_mac_addr_width 48; g_vid_width 12; g_prio_width 3; g_port_mask_bits 9 egress mask width; g_port_id 0 ingress port index of this instance.
REQ-002 Ports (name, direction, width, meaning) SHALL be: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high (decided).
REQ-003 Request ports SHALL be: rq_strobe_p_i in 1 one-cycle request pulse; rq_smac_i in 48; rq_dmac_i in 48; rq_vid_i in 12; rq_has_vid_i in 1; rq_prio_i in 3; rq_has_prio_i in 1; rq_full_o out 1 responder busy.
REQ-004 Response ports SHALL be: rsp_valid_o out 1; rsp_port_mask_o out g_port_mask_bits; rsp_drop_o out 1; rsp_prio_o out 3; rsp_ack_i in 1 consumer accepts response.
REQ-005 Config ports SHALL be: cfg_we_i in 1; cfg_idx_i in clog2(g_num_rules); cfg_mac_i in 48; cfg_mask_i in g_port_mask_bits; cfg_valid_i in 1; cfg_enable_i in 1 global enable; cfg_def_mask_i in g_port_mask_bits flood mask; cfg_def_prio_i in 3.

Function
REQ-006 FSM states SHALL be IDLE, LOOKUP, RESPOND; IDLE->LOOKUP on rq_strobe_p_i; LOOKUP->RESPOND after last rule index; RESPOND->IDLE on rsp_ack_i.
REQ-007 In IDLE, a strobe SHALL latch all rq_* fields in that cycle; rq_full_o SHALL be 0 in IDLE only.
REQ-008 LOOKUP SHALL scan one rule per cycle, index 0..g_num_rules-1, always full length; rsp_valid_o SHALL rise exactly g_num_rules+1 cycles after the strobe edge.
REQ-009 Match SHALL be rule valid and rule mac == latched dmac; the lowest-index match wins; later matches are ignored.
REQ-010 No match SHALL select cfg_def_mask_i, sampled in the last LOOKUP cycle.
REQ-011 Final mask SHALL have bit g_port_id cleared (no hairpin).
REQ-012 rsp_drop_o SHALL be 1 when cfg_enable_i is 0 at the last LOOKUP cycle or the final mask is zero; if drop is 1, rsp_port_mask_o SHALL be 0.
REQ-013 rsp_prio_o SHALL be the latched rq_prio_i if rq_has_prio_i else cfg_def_prio_i.
REQ-014 Response outputs SHALL hold stable while rsp_valid_o=1 and rsp_ack_i=0; rsp_valid_o SHALL drop the cycle after ack.
REQ-015 Strobes while rq_full_o=1 (including the ack cycle) SHALL be ignored; no queuing.
REQ-016 cfg writes SHALL be accepted in any state and visible from the next cycle; a rule written during LOOKUP SHALL affect the scan only if its index has not yet been scanned.
REQ-017 rq_vid_i/rq_has_vid_i SHALL be latched but not affect the result (reserved for VLAN filtering).

Reset
REQ-018 rst_i SHALL force IDLE, rsp_valid_o=0, rsp_port_mask_o=0, rsp_drop_o=0, rsp_prio_o=0, rq_full_o=0, and invalidate all rules, including mid-LOOKUP or mid-RESPOND; there is no response for an aborted request.

Configuration
REQ-019 With RTU_RSP_STATS_EN defined, output rq_ovf_cnt_o (8 bits) SHALL count ignored strobes, saturate at 255, clear on rst_i; without it, the port and counter SHALL be absent.

Structure
REQ-020 Package rtu_rsp_pkg SHALL hold the state enum, the rule struct (valid, mac, mask) and the latched-request struct.
REQ-021 Rule storage SHALL be sub-module rtu_rsp_rule_table: one write port, one indexed combinational read port.

Verification (g_port_id=0, g_num_rules=8, cfg_def_mask_i=0x1FF, enable=1)
REQ-022 Rule0 06:50:ca:fe:ba:be mask 0x002; strobe with that dmac and has_prio=0, def_prio=0 -> mask 0x002, drop 0, prio 0, valid at cycle 9.
REQ-023 Unknown dmac 00:50:ca:fe:ba:be -> mask 0x1FE (bit0 cleared), drop 0.
REQ-024 Rule2 and rule5 same mac, masks 0x004/0x020 -> mask 0x004; rule mask 0x001 only -> mask 0, drop 1.
REQ-025 Hold ack low 20 cycles, strobe at cycle 12 -> outputs stable, strobe ignored, rq_ovf_cnt_o=1 (stats build); ack -> valid 0 next cycle.
REQ-026 rst_i at LOOKUP cycle 4 -> all outputs 0 immediately, rule0 lookup after reset returns flood mask 0x1FE.
